vector100_deserializer: RTL
===========================

// Module: vector100_deserializer
// PURPOSE
//  Collects a serial bit stream into WIDTH-bit words and hands each completed word
//  to the downstream 100-bit vector-reversal stage over a valid/ready interface.
//  - Bits arrive MSB-first.
//  - One bit per cycle sustained; no bubbles between words.
//  - A one-word holding slot absorbs downstream backpressure.
//  - in_sof resynchronises framing; partial words are discarded.
// PARAMETERS
//  WIDTH  100  bits per assembled word (>=2)
// PORTS
//  clk        in   1      rising-edge clock
//  resetn     in   1      asynchronous, active-low reset
//  in_valid   in   1      in_bit/in_sof valid this cycle
//  in_ready   out  1      block can accept a bit this cycle
//  in_bit     in   1      serial data bit; first bit of a word -> out_word[WIDTH-1]
//  in_sof     in   1      qualifies an accepted bit as the first bit of a new word
//  out_valid  out  1      out_word holds a complete word
//  out_ready  in   1      downstream accepts out_word this cycle
//  out_word   out  WIDTH  assembled word
//  drop_pulse out  1      one-cycle flag: a partial word was discarded by in_sof
// BEHAVIOUR
//  - Beat: a bit is accepted when in_valid && in_ready.
//  - Out slot free = !out_valid || out_ready.
//  - State: sr[WIDTH-1:0] shift register; cnt 0..WIDTH-1; st in {FILL, FULL}.
//  - in_ready = (st==FILL). Registered state only; no combinational path from out_ready.
//  - FILL, beat, not last bit: sr <= {sr[WIDTH-2:0],in_bit}; cnt <= cnt+1.
//  - FILL, beat, cnt==WIDTH-1 (last bit), slot free:
//      out_word <= {sr[WIDTH-2:0],in_bit}; out_valid <= 1; cnt <= 0; stay FILL.
//  - FILL, last bit, slot not free:
//      sr <= complete word; st <= FULL; in_ready goes low next cycle.
//  - FULL, slot free: out_word <= sr; out_valid <= 1; cnt <= 0; st <= FILL.
//  - FULL, slot not free: hold all state.
//  - out_valid && !out_ready: out_word and out_valid held stable.
//  - out_valid && out_ready && no new word: out_valid <= 0.
//  - Latency: last bit accepted in cycle N -> out_valid=1 with the word in cycle N+1.
//  - in_sof (sampled on beat only):
//      cnt!=0: partial bits discarded; this bit becomes bit 0 of the count
//              (sr <= {..,in_bit}, cnt <= 1); drop_pulse=1 next cycle only.
//      cnt==0: normal; no drop_pulse.
//    in_sof with WIDTH==1-style completion does not exist (WIDTH>=2).
//  - in_sof is ignored while in_ready=0 (no beat).
//  - Simultaneous events: word completion and a downstream take in the same cycle
//    load the new word directly (no bubble).
//  - Reset values (async, immediate on resetn low): out_valid=0, out_word=0,
//    drop_pulse=0, sr=0, cnt=0, st=FILL (in_ready=1).
//  - Reset mid-word or mid-hold: all data lost; no drop_pulse; first beat after
//    release is bit 0 of a new word regardless of in_sof.
//  - cnt width = $clog2(WIDTH); never exceeds WIDTH-1.
// TESTING
//  1. Reset, out_ready=1, 100 contiguous beats of 99x'0' then '1':
//     -> out_valid=1 exactly one cycle after beat 100; out_word=100'h1; then out_valid=0.
//  2. 200 contiguous beats (word A=all-ones, word B=100'h5555...5), out_ready=1:
//     -> in_ready never low; out_valid pulses one cycle after beats 100 and 200
//        with A then B.
//  3. out_ready=0, 200 beats:
//     -> out_word=A held; in_ready=0 from the cycle after beat 200.
//     Then out_ready=1 for one cycle:
//     -> out_word=B next cycle; in_ready=1 the same cycle.
//  4. 37 beats, then a beat with in_sof=1, then 99 more beats (out_ready=1):
//     -> drop_pulse=1 for exactly one cycle after the sof beat;
//        out_word = the 100 bits starting at the sof bit.
//  5. resetn low asynchronously mid-cycle after beat 50:
//     -> out_valid=0 and in_ready=1 before the next clock edge;
//        100 beats after release yield a clean word; drop_pulse stays 0.
//  6. Random in_valid gaps (30% idle) and random out_ready over 50 words:
//     -> word sequence matches reference model; no word lost or duplicated.

Source files
------------

// File: rtl/vector100_deserializer_if.sv
// Stream bundle between the bit source, the deserializer and the downstream
// vector-reversal stage: serial input side, word output side and the drop flag.
interface vector100_deserializer_if #(
  parameter int WIDTH = 100
);
  logic             in_valid;
  logic             in_ready;
  logic             in_bit;
  logic             in_sof;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_word;
  logic             drop_pulse;

  // Driver side: produces serial bits and accepts assembled words.
  modport master (
    output in_valid, in_bit, in_sof, out_ready,
    input  in_ready, out_valid, out_word, drop_pulse
  );

  // Deserializer side.
  modport slave (
    input  in_valid, in_bit, in_sof, out_ready,
    output in_ready, out_valid, out_word, drop_pulse
  );
endinterface

// File: rtl/vector100_deserializer.sv
// Serial-to-parallel deserializer: gathers MSB-first bits into WIDTH-bit words
// and presents each word on a valid/ready output with a one-word holding slot.
// in_sof on an accepted bit restarts framing and flags any discarded partial word.
module vector100_deserializer #(
  parameter int WIDTH = 100
) (
  input  logic                    clk,
  input  logic                    resetn,
  vector100_deserializer_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  // FULL means a finished word is parked in r_sr waiting for the output slot.
  typedef enum logic {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } state_t;

  state_t           r_st;
  logic [WIDTH-1:0] r_sr;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_out_word;
  logic             r_out_valid;
  logic             r_drop;

  logic             w_beat;
  logic             w_slot_free;
  logic             w_restart;
  logic             w_last;
  logic [WIDTH-1:0] w_shifted;

  // Beat qualification and next-word decode; out_ready only reaches register inputs.
  always_comb begin
    w_beat      = bus.in_valid && (r_st == ST_FILL);
    w_slot_free = !r_out_valid || bus.out_ready;
    w_restart   = w_beat && bus.in_sof && (r_cnt != CNT_ZERO);
    w_last      = w_beat && !w_restart && (r_cnt == CNT_LAST);
    w_shifted   = {r_sr[WIDTH-2:0], bus.in_bit};
  end

  // Framing FSM, shift register, output slot and drop flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_st        <= ST_FILL;
      r_sr        <= {WIDTH{1'b0}};
      r_cnt       <= CNT_ZERO;
      r_out_word  <= {WIDTH{1'b0}};
      r_out_valid <= 1'b0;
      r_drop      <= 1'b0;
    end else begin
      r_drop <= w_restart;
      // A taken word frees the slot unless a new word is loaded below.
      if (r_out_valid && bus.out_ready) begin
        r_out_valid <= 1'b0;
      end else begin
        r_out_valid <= r_out_valid;
      end
      case (r_st)
        ST_FILL: begin
          if (w_restart) begin
            // Stale upper bits in r_sr shift out before the word completes.
            r_sr  <= w_shifted;
            r_cnt <= CNT_ONE;
          end else if (w_last) begin
            r_cnt <= CNT_ZERO;
            if (w_slot_free) begin
              r_out_word  <= w_shifted;
              r_out_valid <= 1'b1;
              r_sr        <= w_shifted;
            end else begin
              r_sr <= w_shifted;
              r_st <= ST_FULL;
            end
          end else if (w_beat) begin
            r_sr  <= w_shifted;
            r_cnt <= r_cnt + CNT_ONE;
          end else begin
            r_sr <= r_sr;
          end
        end
        ST_FULL: begin
          if (w_slot_free) begin
            r_out_word  <= r_sr;
            r_out_valid <= 1'b1;
            r_cnt       <= CNT_ZERO;
            r_st        <= ST_FILL;
          end else begin
            r_st <= ST_FULL;
          end
        end
        default: begin
          r_st <= ST_FILL;
        end
      endcase
    end
  end

  assign bus.in_ready   = (r_st == ST_FILL);
  assign bus.out_valid  = r_out_valid;
  assign bus.out_word   = r_out_word;
  assign bus.drop_pulse = r_drop;

endmodule
